aes_block_serializer: RTL and testbench



---
 rtl/aes_block_serializer.sv | 147 ++++++++++++++
 tb/tb_aes_block_serializer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_block_serializer.sv
// aes_block_serializer
// Buffers complete cipher blocks in a DEPTH-entry FIFO and streams the head
// block out as OUT_W-bit words on the request/ready handshake.
// Optional feature macro: AES_SER_FLUSH_EN adds pi_flush, which empties the
// FIFO and stops output (po_data is held).
//
// state  | meaning
// S_IDLE | no word was presented on the last edge (po_next_val_ready low)
// S_SEND | a word was loaded into po_data on the last edge
module aes_block_serializer #(
    parameter int BLOCK_W   = 128,
    parameter int OUT_W     = 8,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef AES_SER_FLUSH_EN
    input  logic                       pi_flush,
`endif
    input  logic                       pi_blk_valid,
    input  logic [BLOCK_W-1:0]         pi_blk,
    output logic                       po_blk_ready,
    input  logic                       pi_next_val_req,
    output logic                       po_next_val_ready,
    output logic [OUT_W-1:0]           po_data,
    output logic [$clog2(DEPTH+1)-1:0] po_level
);

    localparam int NW  = BLOCK_W / OUT_W;
    localparam int WIW = (NW > 1) ? $clog2(NW) : 1;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH+1);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [BLOCK_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]      r_wptr;
    logic [PW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;
    logic [WIW-1:0]     r_widx;
    logic [OUT_W-1:0]   r_data;

    logic               w_flush;
    logic               w_blk_ready;
    logic               w_send;
    logic               w_last;
    logic               w_push;
    logic               w_pop;
    logic [BLOCK_W-1:0] w_head;
    logic [OUT_W-1:0]   w_word;

`ifdef AES_SER_FLUSH_EN
    assign w_flush = pi_flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_blk_ready       = (r_count != CW'(DEPTH));
    assign po_blk_ready      = w_blk_ready;
    assign po_level          = r_count;
    assign po_data           = r_data;
    assign po_next_val_ready = (r_state == S_SEND);
    assign w_head            = r_mem[r_rptr];

    // Next state and handshake qualifiers; flush overrides both sides.
    always_comb begin
        w_send       = 1'b0;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_last       = (r_widx == WIW'(NW-1));
        w_next_state = S_IDLE;
        if (!w_flush) begin
            w_send = pi_next_val_req && (r_count != '0);
            w_push = pi_blk_valid && w_blk_ready;
            w_pop  = w_send && w_last;
            if (w_send) begin
                w_next_state = S_SEND;
            end
        end
    end

    // Pick word r_widx of the head block in the configured order.
    always_comb begin
        w_word = '0;
        for (int k = 0; k < NW; k++) begin
            if (r_widx == WIW'(k)) begin
                if (MSB_FIRST != 0) begin
                    w_word = w_head[BLOCK_W-1-k*OUT_W -: OUT_W];
                end else begin
                    w_word = w_head[k*OUT_W +: OUT_W];
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Block storage; contents are meaningless while the slot is not counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= pi_blk;
        end
    end

    // Pointers, occupancy, word index and output word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_widx  <= '0;
            r_data  <= '0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_widx  <= '0;
        end else begin
            if (w_send) begin
                r_data <= w_word;
                r_widx <= w_last ? '0 : r_widx + WIW'(1);
            end
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_block_serializer.sv
// Bench for aes_block_serializer: a default instance (8-bit, MSB first) and a
// 32-bit LSB-first instance share the stimulus; each is compared every cycle
// against a list-based block model, plus directed vectors from the block
// 8ea2b7ca516745bfeafc49904b496089.
module tb_aes_block_serializer;

    localparam logic [127:0] BLK = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid;
    logic         req;
    logic         flush;
    logic [127:0] blk;

    logic         br8, nv8, br32, nv32;
    logic [7:0]   d8;
    logic [31:0]  d32;
    logic [2:0]   lvl8, lvl32;

    int errors = 0;
    int checks = 0;

    aes_block_serializer u_dut8 (
        .clk(clk), .rst(rst),
`ifdef AES_SER_FLUSH_EN
        .pi_flush(flush),
`endif
        .pi_blk_valid(valid), .pi_blk(blk), .po_blk_ready(br8),
        .pi_next_val_req(req), .po_next_val_ready(nv8),
        .po_data(d8), .po_level(lvl8)
    );

    aes_block_serializer #(.OUT_W(32), .MSB_FIRST(0)) u_dut32 (
        .clk(clk), .rst(rst),
`ifdef AES_SER_FLUSH_EN
        .pi_flush(flush),
`endif
        .pi_blk_valid(valid), .pi_blk(blk), .po_blk_ready(br32),
        .pi_next_val_req(req), .po_next_val_ready(nv32),
        .po_data(d32), .po_level(lvl32)
    );

    always #5 clk = ~clk;

    // Model: per instance, an ordered list of held blocks (index 0 = head).
    logic [127:0] mb  [2][5];
    int           mc  [2];
    int           mw  [2];
    bit           mr  [2];
    logic [63:0]  md  [2];
    int           owv [2] = '{8, 32};
    bit           msbv[2] = '{1'b1, 1'b0};

    typedef struct {
        bit           v;
        logic [127:0] b;
        bit           rq;
        bit           e_rdy8;
        logic [7:0]   e_d8;
        int           e_lvl8;
        bit           e_rdy32;
        logic [31:0]  e_d32;
    } vec_t;

    vec_t       tbl [18];
    logic [7:0] bytes_exp [16] = '{8'h8e, 8'ha2, 8'hb7, 8'hca, 8'h51, 8'h67, 8'h45, 8'hbf,
                                   8'hea, 8'hfc, 8'h49, 8'h90, 8'h4b, 8'h49, 8'h60, 8'h89};
    logic [31:0] w32_exp [4] = '{32'h4b496089, 32'heafc4990, 32'h516745bf, 32'h8ea2b7ca};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] word_of(input logic [127:0] b, input int ow,
                                            input bit msb, input int k);
        int           nw;
        int           sh;
        logic [127:0] t;
        nw = 128 / ow;
        sh = msb ? (nw - 1 - k) * ow : k * ow;
        t  = b >> sh;
        return t[63:0] & ((64'd1 << ow) - 64'd1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mc[i] = 0; mw[i] = 0; mr[i] = 1'b0; md[i] = '0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit push;
            bit send;
            if (rst) begin
                mc[i] = 0; mw[i] = 0; mr[i] = 1'b0; md[i] = '0;
            end else if (flush) begin
                mc[i] = 0; mw[i] = 0; mr[i] = 1'b0;
            end else begin
                push = valid && (mc[i] < 4);
                send = req && (mc[i] > 0);
                if (send) begin
                    md[i] = word_of(mb[i][0], owv[i], msbv[i], mw[i]);
                    mr[i] = 1'b1;
                    mw[i]++;
                    if (mw[i] == 128 / owv[i]) begin
                        mw[i] = 0;
                        for (int j = 0; j < 4; j++) mb[i][j] = mb[i][j+1];
                        mc[i]--;
                    end
                end else begin
                    mr[i] = 1'b0;
                end
                if (push) begin
                    mb[i][mc[i]] = blk;
                    mc[i]++;
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("rdy8",    nv8,  mr[0]);
        chk("data8",   d8,   md[0][7:0]);
        chk("lvl8",    lvl8, mc[0]);
        chk("blkrdy8", br8,  mc[0] < 4);
        chk("rdy32",   nv32, mr[1]);
        chk("data32",  d32,  md[1][31:0]);
        chk("lvl32",   lvl32, mc[1]);
        chk("blkrdy32", br32, mc[1] < 4);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic drain(input int bound);
        int n = 0;
        valid = 1'b0;
        req   = 1'b1;
        while ((mc[0] != 0 || mc[1] != 0 || mr[0] || mr[1]) && n < bound) begin
            step();
            n++;
        end
        chk("drain_bound", n < bound, 1'b1);
    endtask

    initial begin
        int n;
        logic [127:0] b2;

        rst = 1'b1; valid = 1'b0; req = 1'b0; flush = 1'b0; blk = '0;
        model_reset();
        #2;
        check_outputs();
        step();
        rst = 1'b0;

        // Directed table: one block, request held high.
        for (int k = 0; k < 18; k++) begin
            tbl[k].v       = (k == 0);
            tbl[k].b       = BLK;
            tbl[k].rq      = 1'b1;
            tbl[k].e_rdy8  = (k >= 1 && k <= 16);
            tbl[k].e_d8    = (k == 0) ? 8'h00 : (k <= 16) ? bytes_exp[k-1] : 8'h89;
            tbl[k].e_lvl8  = (k <= 15) ? 1 : 0;
            tbl[k].e_rdy32 = (k >= 1 && k <= 4);
            tbl[k].e_d32   = (k == 0) ? 32'h0 : (k <= 4) ? w32_exp[k-1] : 32'h8ea2b7ca;
        end
        for (int k = 0; k < 18; k++) begin
            valid = tbl[k].v; blk = tbl[k].b; req = tbl[k].rq;
            step();
            chk("tbl_rdy8",  nv8,  tbl[k].e_rdy8);
            chk("tbl_d8",    d8,   tbl[k].e_d8);
            chk("tbl_lvl8",  lvl8, tbl[k].e_lvl8);
            chk("tbl_rdy32", nv32, tbl[k].e_rdy32);
            chk("tbl_d32",   d32,  tbl[k].e_d32);
        end
        valid = 1'b0;
        step();

        // Fill without request: 4 blocks fit, the 5th is held off.
        req = 1'b0;
        valid = 1'b1;
        for (int p = 0; p < 4; p++) begin
            blk = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        chk("full_blkrdy", br8, 1'b0);
        chk("full_level", lvl8, 3'd4);
        blk = {$urandom, $urandom, $urandom, $urandom};
        step();
        chk("held_level", lvl8, 3'd4);
        req = 1'b1;
        n = 0;
        while (br8 !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("blkrdy_return_cycles", n, 16);
        step();
        valid = 1'b0;
        drain(300);

        // Request dropped after byte 5 for 7 cycles.
        valid = 1'b1; blk = BLK; req = 1'b1;
        step();
        valid = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("byte5", d8, 8'h51);
        req = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            chk("gap_no_ready", nv8, 1'b0);
        end
        req = 1'b1;
        step();
        chk("resume_byte6", d8, 8'h67);
        chk("resume_ready", nv8, 1'b1);
        drain(40);

        // Asynchronous reset mid-block.
        valid = 1'b1; blk = BLK; req = 1'b1;
        step();
        valid = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk("pre_rst_byte3", d8, 8'hb7);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        chk("rst_ready", nv8, 1'b0);
        chk("rst_data", d8, 8'h00);
        chk("rst_blkrdy", br8, 1'b1);
        step();
        rst = 1'b0;
        b2 = {$urandom, $urandom, $urandom, $urandom};
        valid = 1'b1; blk = b2;
        step();
        valid = 1'b0;
        step();
        chk("after_rst_first8", d8, b2[127:120]);
        chk("after_rst_first32", d32, b2[31:0]);
        drain(40);

        // Randomized traffic against the model.
        for (int c = 0; c < 500; c++) begin
            valid = 1'($urandom_range(0, 1));
            req   = ($urandom_range(0, 3) != 0);
            blk   = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        drain(300);

`ifdef AES_SER_FLUSH_EN
        req = 1'b0; valid = 1'b1;
        for (int p = 0; p < 2; p++) begin
            blk = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        chk("preflush_level", lvl8, 3'd2);
        flush = 1'b1;
        step();
        flush = 1'b0; valid = 1'b0;
        chk("flush_level", lvl8, 3'd0);
        chk("flush_blkrdy", br8, 1'b1);
        req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("flush_no_ready", nv8, 1'b0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
